// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier.
// Holds the fixed datapath widths, the step count and the FSM state type.
package mult_pkg;

  localparam int OP_W      = 4;  // operand width
  localparam int PROD_W    = 8;  // product / accumulator width
  localparam int NUM_STEPS = 4;  // one shift-add step per multiplier bit
  localparam int CNT_W     = 2;  // wide enough to count NUM_STEPS steps

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_multiplier_full_adder.sv
// 4-bit ripple-carry adder used by the multiplier datapath.
// Ports:
//   a, b  : 4-bit addends
//   cin   : carry in
//   sum   : 4-bit sum
//   cout  : carry out of the top bit
module full_adder
  import mult_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  input  logic            cin,
  output logic [OP_W-1:0] sum,
  output logic            cout
);

  logic [OP_W:0] carry;

  // NOTE: every signal written in a combinational block gets a value on every
  // path (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < OP_W; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[OP_W];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential 4x4 unsigned shift-add multiplier.
// A start in IDLE captures the operands; four CALC cycles each add the
// multiplicand into the upper half of the accumulator (when the current
// multiplier bit is set) and shift right; the product is registered on the
// last step and announced by a one-cycle done pulse.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   start   : request a multiply (only honoured in IDLE)
//   a, b    : unsigned multiplicand / multiplier
//   product : registered a*b, held until the next result
//   busy    : high while calculating
//   done    : one-cycle pulse when product is new
module shift_add_multiplier
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] product,
  output logic              busy,
  output logic              done
);

  state_t              state_q,   state_d;
  logic [OP_W-1:0]     mcand_q,   mcand_d;
  logic [PROD_W-1:0]   acc_q,     acc_d;
  logic [CNT_W-1:0]    count_q,   count_d;
  logic [PROD_W-1:0]   product_q, product_d;
  logic                busy_q,    busy_d;
  logic                done_q,    done_d;

  logic [OP_W-1:0]     add_sum;
  logic                add_cout;
  logic [PROD_W-1:0]   step_acc;

  // Upper half of the accumulator plus the multiplicand.
  full_adder u_adder (
    .a    (acc_q[PROD_W-1:OP_W]),
    .b    (mcand_q),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // One shift-add step. The adder carry lands in acc[7] after the shift, so
  // no bit of the partial product is ever lost.
  always_comb begin
    if (acc_q[0]) begin
      step_acc = {add_cout, add_sum, acc_q[OP_W-1:1]};
    end else begin
      step_acc = {1'b0, acc_q[PROD_W-1:OP_W], acc_q[OP_W-1:1]};
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          mcand_d = a;
          acc_d   = {{(PROD_W-OP_W){1'b0}}, b};
          count_d = '0;
        end
      end
      CALC: begin
        acc_d   = step_acc;
        count_d = count_q + 1'b1;
        if (count_q == CNT_W'(NUM_STEPS - 1)) begin
          state_d   = DONE;
          product_d = step_acc;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are derived from the next state so they are registered
    // alongside it and line up exactly with the CALC / DONE cycles.
    busy_d = (state_d == CALC);
    done_d = (state_d == DONE);
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values of the others.
  // NOTE: all datapath registers are reset, not just the FSM, so an aborted
  // operation leaves no stale partial product behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier.
// Expected products (plain a*b) are queued when a multiply is issued; a
// monitor pops and compares them whenever done is seen.
module tb_shift_add_multiplier;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a_i;
  logic [3:0] b_i;
  logic [7:0] product;
  logic       busy;
  logic       done;

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  shift_add_multiplier dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a_i),
    .b       (b_i),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: done high with product %0h, no request outstanding", product);
      end else begin
        check("product", product, exp_q.pop_front());
      end
    end
  end

  // Issue one multiply and follow it to its done pulse, checking timing.
  // With perturb set, operands change and start pulses again mid-calculation.
  task automatic do_mult(input logic [3:0] x, input logic [3:0] y, input bit perturb,
                         output time t_done);
    logic [7:0] e;
    int         lat;
    int         busy_cnt;
    @(negedge clk);
    a_i   = x;
    b_i   = y;
    start = 1'b1;
    e     = 8'(int'(x) * int'(y));
    exp_q.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_cnt++;
      if (perturb && lat == 1) begin
        a_i   = x ^ 4'h5;
        b_i   = y + 4'd1;
        start = 1'b1;
      end
      if (perturb && lat == 2) start = 1'b0;
      @(negedge clk);
      lat++;
    end
    t_done = $time;
    check($sformatf("latency_%0dx%0d", x, y), lat, 4);
    check($sformatf("busy_cycles_%0dx%0d", x, y), busy_cnt, 4);
    check("busy_low_in_done", busy, 0);
    if (perturb) begin
      @(negedge clk);
      check("done_single_pulse", done, 0);
      check("busy_not_extended", busy, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    time t1, t2;
    rst   = 1'b1;
    start = 1'b0;
    a_i   = '0;
    b_i   = '0;
    repeat (3) @(negedge clk);
    check("reset_product", product, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst = 1'b0;

    // Directed cases.
    do_mult(4'd9,  4'd6,  1'b0, t1);
    do_mult(4'hF,  4'hF,  1'b0, t1);
    do_mult(4'd0,  4'd13, 1'b0, t1);
    do_mult(4'd13, 4'd0,  1'b0, t1);
    do_mult(4'd9,  4'd6,  1'b1, t1);

    // Abort in the second CALC cycle; a start alongside rst is ignored.
    @(negedge clk);
    a_i   = 4'hF;
    b_i   = 4'hF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_product", product, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    do_mult(4'd3, 4'd5, 1'b0, t1);

    // Back-to-back: second start in the cycle after done.
    do_mult(4'd2, 4'd3, 1'b0, t1);
    do_mult(4'd7, 4'd7, 1'b0, t2);
    check("b2b_period_cycles", int'((t2 - t1) / 10), 6);

    // Random operands.
    for (int i = 0; i < 30; i++) begin
      do_mult(4'($urandom_range(15)), 4'($urandom_range(15)), 1'b0, t1);
    end

    // Exhaustive sweep.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        do_mult(4'(x), 4'(y), 1'b0, t1);
      end
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
